// File: rtl/sram_bridge_16.sv
// 32-bit LSU access to 16-bit async SRAM bridge, one request in flight.
// Optional: SRAM_ALIGN_CHK_EN adds o_err and rejects misaligned requests.
module sram_bridge_16 #(
    parameter int ADDR_W   = 18,
    parameter int WAIT_CYC = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_wren,
    input  logic [31:0]       i_addr,
    input  logic [3:0]        i_bmask,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_ack,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_sram_addr,
    inout  wire  [15:0]       io_sram_dq,
    output logic              o_sram_ce_n,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n
`ifdef SRAM_ALIGN_CHK_EN
    ,
    output logic              o_err
`endif
);

    localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE, LO_SETUP, LO_STRB, HI_SETUP, HI_STRB, ACK
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-2:0] waddr_q, waddr_d;
    logic [3:0]        bmask_q, bmask_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              hi, drive, last, misal, rd_op;
    logic [15:0]       lo_msk, hi_msk;
    logic              unused;

    assign unused = ^{i_addr[31:ADDR_W+1], i_addr[1:0]};
    assign last   = (cnt_q == CW'(WAIT_CYC - 1));
    assign lo_msk = {{8{bmask_q[1]}}, {8{bmask_q[0]}}};
    assign hi_msk = {{8{bmask_q[3]}}, {8{bmask_q[2]}}};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wren_d      = wren_q;
        waddr_d     = waddr_q;
        bmask_d     = bmask_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        hi          = 1'b0;
        drive       = 1'b0;
        misal       = 1'b0;
        o_sram_ce_n = 1'b1;
        o_sram_we_n = 1'b1;
        o_sram_oe_n = 1'b1;
        o_sram_lb_n = 1'b1;
        o_sram_ub_n = 1'b1;
        o_ack       = 1'b0;
`ifdef SRAM_ALIGN_CHK_EN
        misal = (i_addr[1:0] != 2'b00);
`endif
        unique case (state_q)
            IDLE: begin
                if (i_req) begin
                    wren_d  = i_wren;
                    waddr_d = i_addr[ADDR_W:2];
                    bmask_d = i_bmask;
                    wdata_d = i_wdata;
                    rbuf_d  = '0;
                    err_d   = misal;
                    if (misal)
                        state_d = ACK;
                    else if (|i_bmask[1:0])
                        state_d = LO_SETUP;
                    else if (|i_bmask[3:2])
                        state_d = HI_SETUP;
                    else
                        state_d = ACK;
                end
            end
            LO_SETUP, HI_SETUP: begin
                hi          = (state_q == HI_SETUP);
                o_sram_ce_n = 1'b0;
                o_sram_lb_n = hi ? ~bmask_q[2] : ~bmask_q[0];
                o_sram_ub_n = hi ? ~bmask_q[3] : ~bmask_q[1];
                drive       = wren_q;
                cnt_d       = '0;
                state_d     = hi ? HI_STRB : LO_STRB;
            end
            LO_STRB, HI_STRB: begin
                hi          = (state_q == HI_STRB);
                o_sram_ce_n = 1'b0;
                o_sram_we_n = ~wren_q;
                o_sram_oe_n = wren_q;
                o_sram_lb_n = hi ? ~bmask_q[2] : ~bmask_q[0];
                o_sram_ub_n = hi ? ~bmask_q[3] : ~bmask_q[1];
                drive       = wren_q;
                cnt_d       = cnt_q + CW'(1);
                if (last) begin
                    if (!wren_q) begin
                        if (hi)
                            rbuf_d[31:16] = io_sram_dq & hi_msk;
                        else
                            rbuf_d[15:0] = io_sram_dq & lo_msk;
                    end
                    if (!hi && (|bmask_q[3:2]))
                        state_d = HI_SETUP;
                    else
                        state_d = ACK;
                end
            end
            ACK: begin
                o_ack   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Load data becomes visible on the edge that enters ACK
        rd_op = (state_q == IDLE) ? ~i_wren : ~wren_q;
        if (state_q != ACK && state_d == ACK && rd_op && !err_d)
            rdata_d = rbuf_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wren_q  <= 1'b0;
            waddr_q <= '0;
            bmask_q <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wren_q  <= wren_d;
            waddr_q <= waddr_d;
            bmask_q <= bmask_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign o_rdata     = rdata_q;
    assign o_busy      = (state_q != IDLE);
    assign o_sram_addr = {waddr_q, hi};
    assign io_sram_dq  = drive ? (hi ? wdata_q[31:16] : wdata_q[15:0]) : 16'bz;

`ifdef SRAM_ALIGN_CHK_EN
    assign o_err = err_q & (state_q == ACK);
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_sram_bridge_16.sv
// Directed bench for sram_bridge_16 with a byte-lane SRAM model
// and a scoreboard of expected read data and ack latency.
module tb_sram_bridge_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wren;
    logic [31:0] addr, wdata;
    logic [3:0]  bmask;
    logic [31:0] rdata;
    logic        ack, busy;
    logic [17:0] saddr;
    wire  [15:0] dq;
    logic        ce_n, we_n, oe_n, lb_n, ub_n;
`ifdef SRAM_ALIGN_CHK_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    sram_bridge_16 #(.ADDR_W(18), .WAIT_CYC(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_wren(wren),
        .i_addr(addr), .i_bmask(bmask), .i_wdata(wdata),
        .o_rdata(rdata), .o_ack(ack), .o_busy(busy),
        .o_sram_addr(saddr), .io_sram_dq(dq),
        .o_sram_ce_n(ce_n), .o_sram_we_n(we_n), .o_sram_oe_n(oe_n),
        .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
`ifdef SRAM_ALIGN_CHK_EN
        , .o_err(err)
`endif
    );

    // Async SRAM model: reads while oe_n low, byte writes at the edge ending we_n
    logic [15:0] mem [0:255];
    assign dq = (!ce_n && !oe_n && we_n) ? mem[saddr[7:0]] : 16'bz;
    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) mem[saddr[7:0]][7:0] <= dq[7:0];
            if (!ub_n) mem[saddr[7:0]][15:8] <= dq[15:8];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        logic        rd;
    } exp_t;
    exp_t sb[$];

    int passed = 0;
    int total  = 0;
    int we_cnt, oe_cnt, ce_cnt, acks;
    logic        busy1, err_seen;
    logic [17:0] we_a [2];
    logic [15:0] we_d [2];
    logic [1:0]  we_bl [2];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic access(input logic wr, input logic [31:0] a,
                          input logic [3:0] m, input logic [31:0] wd,
                          input logic [31:0] erd, input int elat);
        exp_t e;
        int n;
        e.rdata = erd;
        e.lat   = elat;
        e.rd    = ~wr;
        sb.push_back(e);
        @(posedge clk); #1;
        req = 1'b1; wren = wr; addr = a; bmask = m; wdata = wd;
        n = 0; we_cnt = 0; oe_cnt = 0; ce_cnt = 0;
        busy1 = 1'b0; err_seen = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) busy1 = busy;
            if (!ce_n) ce_cnt++;
            if (!oe_n) oe_cnt++;
            if (!we_n) begin
                if (we_cnt < 2) begin
                    we_a[we_cnt]  = saddr;
                    we_d[we_cnt]  = dq;
                    we_bl[we_cnt] = {lb_n, ub_n};
                end
                we_cnt++;
            end
        end while (!ack && n < 40);
`ifdef SRAM_ALIGN_CHK_EN
        err_seen = err;
`endif
        req = 1'b0;
        check("ack_seen", {31'd0, ack}, 32'd1);
        e = sb.pop_front();
        check("latency", 32'(n), 32'(e.lat));
        if (e.rd) check("rdata", rdata, e.rdata);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; wren = 1'b0;
        addr = '0; bmask = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_addr", {14'd0, saddr}, 32'd0);
        check("rst_pins", {27'd0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
        rst = 1'b0;

        access(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'h0, 5);
        check("sw_we_cnt", 32'(we_cnt), 32'd2);
        check("sw_addr0", {14'd0, we_a[0]}, 32'h8);
        check("sw_dq0", {16'd0, we_d[0]}, 32'hBEEF);
        check("sw_addr1", {14'd0, we_a[1]}, 32'h9);
        check("sw_dq1", {16'd0, we_d[1]}, 32'hDEAD);
        check("sw_ce_cnt", 32'(ce_cnt), 32'd4);
        check("sw_busy", {31'd0, busy1}, 32'd1);

        access(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF, 5);
        check("lw_oe_cnt", 32'(oe_cnt), 32'd2);
        check("lw_we_cnt", 32'(we_cnt), 32'd0);

        access(1'b1, 32'h13, 4'h8, 32'hAA00_0000, 32'h0, 3);
        check("sb_we_cnt", 32'(we_cnt), 32'd1);
        check("sb_addr", {14'd0, we_a[0]}, 32'h9);
        check("sb_lbub", {30'd0, we_bl[0]}, 32'h2);
        check("sb_dq_hi", {24'd0, we_d[0][15:8]}, 32'hAA);

        access(1'b0, 32'h10, 4'hF, 32'h0, 32'hAAAD_BEEF, 5);

        access(1'b1, 32'h10, 4'h0, 32'h1111_1111, 32'h0, 1);
        check("m0_ce_cnt", 32'(ce_cnt), 32'd0);
        check("m0_rdata_kept", rdata, 32'hAAAD_BEEF);

        access(1'b0, 32'h10, 4'h3, 32'h0, 32'h0000_BEEF, 3);
        check("lh_oe_cnt", 32'(oe_cnt), 32'd1);
        access(1'b0, 32'h10, 4'hC, 32'h0, 32'hAAAD_0000, 3);
        access(1'b0, 32'h0008_0010, 4'hF, 32'h0, 32'hAAAD_BEEF, 5);

        // Reset in the strobe cycle of a write
        @(posedge clk); #1;
        req = 1'b1; wren = 1'b1; addr = 32'h20;
        bmask = 4'hF; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("strb_we", {31'd0, we_n}, 32'd0);
        rst = 1'b1;
        #1;
        check("abort_we", {31'd0, we_n}, 32'd1);
        check("abort_ce", {31'd0, ce_n}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ack", {31'd0, ack}, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        acks = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'd0);

        access(1'b0, 32'h10, 4'hF, 32'h0, 32'hAAAD_BEEF, 5);

`ifdef SRAM_ALIGN_CHK_EN
        access(1'b0, 32'h12, 4'hF, 32'h0, 32'hAAAD_BEEF, 1);
        check("misal_err", {31'd0, err_seen}, 32'd1);
        check("misal_ce_cnt", 32'(ce_cnt), 32'd0);
        access(1'b0, 32'h10, 4'hF, 32'h0, 32'hAAAD_BEEF, 5);
        check("ok_err", {31'd0, err_seen}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
